pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard controller for the five-stage MIPS pipeline. Decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM pipeline registers load, hold or take a bubble. Resolves load-use stalls, taken-branch flushes and multi-cycle ALU occupancy, and drives the EX-stage operand forwarding selects. Sits beside the pipeline registers and clocks on the same falling edge as they do.

## Interface
Parameters:
- MC_LATENCY, 4: total EX-stage cycles of a multi-cycle ALU op; legal range 2..16.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- rst  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
- ex_dst  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- ex_mc_start  in  1  first EX cycle of a multi-cycle ALU op.
- mem_dst, mem_reg_write  in  5, 1  EX/MEM destination and write enable.
- wb_dst, wb_reg_write  in  5, 1  MEM/WB destination and write enable.
- pc_en, if_id_en, id_ex_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_bubble  out  1 each  insert a NOP into that register.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- busy  out  1  FSM is in MC_BUSY.
- stall_cycles, flush_count  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN and MC_BUSY. There is a 4-bit down-counter `cnt`.
- **Priority** (RUN only): branch flush, then multi-cycle start, then load-use.
- **Branch** (RUN, ex_branch_taken):
  - if_id_flush=1, id_ex_flush=1, pc_en=1.
  - flush_count increments.
  - Overrides any load-use condition and ignores ex_mc_start in the same cycle.
- **Multi-cycle start** (RUN, ex_mc_start):
  - Freeze this cycle: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1.
  - cnt ← MC_LATENCY−2; next state MC_BUSY.
- **MC_BUSY**:
  - If cnt≠0: freeze as above and decrement cnt.
  - If cnt==0: no freeze, so EX/MEM captures the result; next state RUN.
  - ex_mc_start and ex_branch_taken are ignored in this state.
- **Load-use** (RUN, no branch, no mc start):
  - Condition: ex_mem_read, ex_dst≠0, and either ex_dst==id_rs or (id_uses_rt and ex_dst==id_rt).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1. One cycle only; forwarding from MEM/WB covers the following cycle.
- **Idle** (no event): all enables 1, all flush/bubble outputs 0.
- **Forwarding** (combinational, any state; rule shown for fwd_a using ex_rs, fwd_b is identical using ex_rt):
  - 10 if mem_reg_write and mem_dst≠0 and mem_dst==ex_rs.
  - Otherwise 01 if wb_reg_write and wb_dst≠0 and wb_dst==ex_rs.
  - Otherwise 00. EX/MEM wins over MEM/WB.
- **stall_cycles** increments in every cycle in which pc_en=0. Both counters wrap modulo 2^CNT_W.

## Timing
- FSM, cnt and both counters are registered on the falling edge of clk.
- All enable, flush, bubble and fwd outputs are Mealy-combinational and must settle within the high phase.
- On a falling edge with rst=1: state=RUN, cnt=0, stall_cycles=0, flush_count=0, busy=0. Combinational outputs then follow the idle/RUN rules for the current inputs.
- Reset asserted during MC_BUSY aborts the op; the next cycle is RUN with no freeze.
- Multi-cycle op: MC_LATENCY EX cycles, of which the first MC_LATENCY−1 are frozen.
- Load-use: exactly one bubble per hazard.
- Branch: two NOPs, inserted in the same cycle.

## Structure
- Shared package mips_pipe_pkg holds:
  - the state enum {RUN, MC_BUSY};
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the register-number width constant (5).
- One sub-module, fwd_sel: a combinational compare/priority block instantiated twice, once for fwd_a and once for fwd_b.

## Test plan
- Reset mid-MC_BUSY with cnt=2 → next cycle busy=0, pc_en=1, both counters 0.
- lw $3 in EX (ex_dst=3, ex_mem_read=1), id_rs=3 → one cycle with pc_en=0, id_ex_flush=1; next cycle pc_en=1; stall_cycles=1.
- ex_branch_taken=1 together with a load-use hazard → if_id_flush=id_ex_flush=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- MC_LATENCY=4, ex_mc_start pulse → ex_mem_bubble=1 for 3 cycles, released on the 4th; busy high for 3 cycles; stall_cycles=3.
- ex_rs=5, mem_dst=5, wb_dst=5, both write enables 1 → fwd_a=10; with mem_dst=0 → fwd_a=01; with ex_rt=0 → fwd_b=00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// mips_pipe_pkg: shared types and constants for the MIPS pipeline hazard logic
package mips_pipe_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_t;
  typedef enum logic {RUN, MC_BUSY} state_t;
  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_REG = 2'b00;
  localparam fwd_t FWD_WB  = 2'b01;
  localparam fwd_t FWD_MEM = 2'b10;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: signal bundle between the pipeline datapath and the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  import mips_pipe_pkg::*;
  reg_t id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic id_uses_rt, ex_mem_read, ex_branch_taken, ex_mc_start, mem_reg_write, wb_reg_write;
  logic pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, busy;
  fwd_t fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dst, ex_mem_read, ex_branch_taken,
           ex_mc_start, mem_dst, mem_reg_write, wb_dst, wb_reg_write,
    input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble,
           fwd_a, fwd_b, busy, stall_cycles, flush_count
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dst, ex_mem_read, ex_branch_taken,
           ex_mc_start, mem_dst, mem_reg_write, wb_dst, wb_reg_write,
    output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble,
           fwd_a, fwd_b, busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// fwd_sel: EX operand forwarding select, EX/MEM result preferred over MEM/WB
module fwd_sel
  import mips_pipe_pkg::*;
(
  input  reg_t src,
  input  reg_t mem_dst,
  input  logic mem_reg_write,
  input  reg_t wb_dst,
  input  logic wb_reg_write,
  output fwd_t sel
);
  always_comb
    sel = (mem_reg_write && mem_dst != '0 && mem_dst == src) ? FWD_MEM :
          (wb_reg_write && wb_dst != '0 && wb_dst == src) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble control and operand forwarding for the 5-stage pipeline
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 2);
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic hazard, branch, mc_start, load_use, freeze, pc_en;
  assign hazard = bus.ex_mem_read && bus.ex_dst != '0 &&
                  (bus.ex_dst == bus.id_rs || (bus.id_uses_rt && bus.ex_dst == bus.id_rt));
  // state and counters move on the falling edge, in step with the pipeline registers
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      stall_cycles <= stall_cycles + CNT_W'(!pc_en);
      flush_count <= flush_count + CNT_W'(branch);
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    branch = 1'b0;
    mc_start = 1'b0;
    load_use = 1'b0;
    freeze = 1'b0;
    if (state == RUN) begin
      branch = bus.ex_branch_taken;
      mc_start = !branch && bus.ex_mc_start;
      load_use = !branch && !bus.ex_mc_start && hazard;
      freeze = mc_start;
      state_nxt = mc_start ? MC_BUSY : RUN;
      cnt_nxt = mc_start ? CNT_INIT : cnt;
    end else begin
      freeze = cnt != '0;
      state_nxt = freeze ? MC_BUSY : RUN;
      cnt_nxt = freeze ? cnt - 4'd1 : cnt;
    end
    pc_en = !freeze && !load_use;
  end
  assign bus.pc_en = pc_en;
  assign bus.if_id_en = pc_en;
  assign bus.id_ex_en = !freeze;
  assign bus.if_id_flush = branch;
  assign bus.id_ex_flush = branch || load_use;
  assign bus.ex_mem_bubble = freeze;
  assign bus.busy = state == MC_BUSY;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count = flush_count;
  fwd_sel u_fwd_a (
    .src(bus.ex_rs), .mem_dst(bus.mem_dst), .mem_reg_write(bus.mem_reg_write),
    .wb_dst(bus.wb_dst), .wb_reg_write(bus.wb_reg_write), .sel(bus.fwd_a)
  );
  fwd_sel u_fwd_b (
    .src(bus.ex_rt), .mem_dst(bus.mem_dst), .mem_reg_write(bus.mem_reg_write),
    .wb_dst(bus.wb_dst), .wb_reg_write(bus.wb_reg_write), .sel(bus.fwd_b)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus randomized check against a cycle-count reference model
module tb_pipeline_hazard_ctrl;
  localparam int MCL = 4;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int rem = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus();
  pipeline_hazard_ctrl #(.MC_LATENCY(MCL), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [1:0] fwd_m(input logic [4:0] s);
    if (bus.mem_reg_write && bus.mem_dst != 0 && bus.mem_dst == s) return 2'b10;
    if (bus.wb_reg_write && bus.wb_dst != 0 && bus.wb_dst == s) return 2'b01;
    return 2'b00;
  endfunction
  task automatic idle();
    {bus.id_rs, bus.id_rt, bus.ex_rs, bus.ex_rt, bus.ex_dst, bus.mem_dst, bus.wb_dst} = '0;
    {bus.id_uses_rt, bus.ex_mem_read, bus.ex_branch_taken, bus.ex_mc_start} = '0;
    {bus.mem_reg_write, bus.wb_reg_write} = '0;
  endtask
  task automatic randomize_inputs();
    bus.id_rs = 5'($urandom_range(0, 4));
    bus.id_rt = 5'($urandom_range(0, 4));
    bus.ex_rs = 5'($urandom_range(0, 4));
    bus.ex_rt = 5'($urandom_range(0, 4));
    bus.ex_dst = 5'($urandom_range(0, 4));
    bus.mem_dst = 5'($urandom_range(0, 4));
    bus.wb_dst = 5'($urandom_range(0, 4));
    bus.id_uses_rt = 1'($urandom);
    bus.ex_mem_read = 1'($urandom);
    bus.ex_branch_taken = $urandom_range(0, 5) == 0;
    bus.ex_mc_start = $urandom_range(0, 7) == 0;
    bus.mem_reg_write = 1'($urandom);
    bus.wb_reg_write = 1'($urandom);
    rst = $urandom_range(0, 99) == 0;
  endtask
  // rem = EX cycles still owed to a multi-cycle op; only the last one is unfrozen
  task automatic step();
    bit br, mc, lu, frz, pce;
    @(posedge clk);
    br = rem == 0 && bus.ex_branch_taken;
    mc = rem == 0 && !br && bus.ex_mc_start;
    lu = rem == 0 && !br && !bus.ex_mc_start && bus.ex_mem_read && bus.ex_dst != 0 &&
         (bus.ex_dst == bus.id_rs || (bus.id_uses_rt && bus.ex_dst == bus.id_rt));
    frz = mc || rem > 1;
    pce = !frz && !lu;
    check("pc_en", CW'(bus.pc_en), CW'(pce));
    check("if_id_en", CW'(bus.if_id_en), CW'(pce));
    check("id_ex_en", CW'(bus.id_ex_en), CW'(!frz));
    check("if_id_flush", CW'(bus.if_id_flush), CW'(br));
    check("id_ex_flush", CW'(bus.id_ex_flush), CW'(br || lu));
    check("ex_mem_bubble", CW'(bus.ex_mem_bubble), CW'(frz));
    check("busy", CW'(bus.busy), CW'(rem > 0));
    check("fwd_a", CW'(bus.fwd_a), CW'(fwd_m(bus.ex_rs)));
    check("fwd_b", CW'(bus.fwd_b), CW'(fwd_m(bus.ex_rt)));
    check("stall_cycles", bus.stall_cycles, m_stall);
    check("flush_count", bus.flush_count, m_flush);
    if (rst) begin
      rem = 0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall += CW'(!pce);
      m_flush += CW'(br);
      rem = mc ? MCL - 1 : (rem > 0 ? rem - 1 : 0);
    end
    @(negedge clk);
    #1;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    step();
    rst = 1'b0;
    #1;
    check("rst_busy", CW'(bus.busy), 0);
    check("rst_stall", bus.stall_cycles, 0);
    bus.ex_mem_read = 1'b1;
    bus.ex_dst = 5'd3;
    bus.id_rs = 5'd3;
    #1;
    check("lu_pc_en", CW'(bus.pc_en), 0);
    check("lu_id_ex_flush", CW'(bus.id_ex_flush), 1);
    step();
    idle();
    #1;
    check("lu_release", CW'(bus.pc_en), 1);
    check("lu_stall", bus.stall_cycles, 1);
    bus.ex_mem_read = 1'b1;
    bus.ex_dst = 5'd3;
    bus.id_rs = 5'd3;
    bus.ex_branch_taken = 1'b1;
    #1;
    check("br_if_id_flush", CW'(bus.if_id_flush), 1);
    check("br_id_ex_flush", CW'(bus.id_ex_flush), 1);
    check("br_pc_en", CW'(bus.pc_en), 1);
    step();
    idle();
    #1;
    check("br_flush_count", bus.flush_count, 1);
    check("br_stall", bus.stall_cycles, 1);
    bus.ex_mc_start = 1'b1;
    #1;
    check("mc_bubble", CW'(bus.ex_mem_bubble), 1);
    step();
    bus.ex_mc_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("mc_stall", bus.stall_cycles, 4);
    check("mc_done", CW'(bus.busy), 0);
    bus.ex_mc_start = 1'b1;
    step();
    bus.ex_mc_start = 1'b0;
    check("mc_busy", CW'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("abort_busy", CW'(bus.busy), 0);
    check("abort_pc_en", CW'(bus.pc_en), 1);
    check("abort_stall", bus.stall_cycles, 0);
    check("abort_flush", bus.flush_count, 0);
    bus.ex_rs = 5'd5;
    bus.ex_rt = 5'd5;
    bus.mem_dst = 5'd5;
    bus.wb_dst = 5'd5;
    bus.mem_reg_write = 1'b1;
    bus.wb_reg_write = 1'b1;
    #1;
    check("fwd_mem", CW'(bus.fwd_a), 2);
    bus.mem_dst = 5'd0;
    #1;
    check("fwd_wb", CW'(bus.fwd_a), 1);
    bus.ex_rt = 5'd0;
    #1;
    check("fwd_zero", CW'(bus.fwd_b), 0);
    step();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
